// File: rtl/axil_rd_arbiter.sv
// Round-robin AXI4-Lite read arbiter: NUM_M masters share one slave, one read in flight.
// Latency: grant at T, S_ARVALID at T+1, earliest M_RVALID at T+2; out-of-range reads answered with DECERR.
// Backpressure: S_ARREADY stalls the address phase, M_RREADY of the granted master is passed to S_RREADY.
module axil_rd_arbiter #(
   parameter int                    NUM_M      = 2,
   parameter int                    AXI_AWIDTH = 32,
   parameter int                    AXI_DWIDTH = 32,
   parameter logic [AXI_AWIDTH-1:0] ADDR_LO    = AXI_AWIDTH'(32'h00000000),
   parameter logic [AXI_AWIDTH-1:0] ADDR_HI    = AXI_AWIDTH'(32'h3FFFFFFF)
) (
   input  logic                        ACLK,
   input  logic                        ARESETN,
   input  logic [NUM_M*AXI_AWIDTH-1:0] M_ARADDR,
   input  logic [NUM_M*3-1:0]          M_ARPROT,
   input  logic [NUM_M-1:0]            M_ARVALID,
   output logic [NUM_M-1:0]            M_ARREADY,
   output logic [NUM_M*AXI_DWIDTH-1:0] M_RDATA,
   output logic [NUM_M*2-1:0]          M_RRESP,
   output logic [NUM_M-1:0]            M_RVALID,
   input  logic [NUM_M-1:0]            M_RREADY,
   output logic [AXI_AWIDTH-1:0]       S_ARADDR,
   output logic [2:0]                  S_ARPROT,
   output logic                        S_ARVALID,
   input  logic                        S_ARREADY,
   input  logic [AXI_DWIDTH-1:0]       S_RDATA,
   input  logic [1:0]                  S_RRESP,
   input  logic                        S_RVALID,
   output logic                        S_RREADY
);

   localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   // Window size; an address is in range when its offset from ADDR_LO does not exceed this.
   localparam logic [AXI_AWIDTH-1:0] SPAN = ADDR_HI - ADDR_LO;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [GW-1:0]           last_grant_q, last_grant_d;
   logic [GW-1:0]           gnt_q, gnt_d;
   logic [AXI_AWIDTH-1:0]   addr_q, addr_d;
   logic [2:0]              prot_q, prot_d;

   logic                    any_req;
   logic [GW-1:0]           grant_idx;
   logic [AXI_AWIDTH-1:0]   sel_addr;
   logic [2:0]              sel_prot;
   logic [AXI_AWIDTH-1:0]   sel_offset;
   logic                    in_range;

   // Round-robin pick: first requester after the last completed grant, wrapping modulo NUM_M,
   // so only encodings 0..NUM_M-1 can ever be produced.
   always_comb begin
      int idx;
      idx       = 0;
      any_req   = 1'b0;
      grant_idx = '0;
      for (int k = 1; k <= NUM_M; k++) begin
         idx = (int'(last_grant_q) + k) % NUM_M;
         if (!any_req && M_ARVALID[idx]) begin
            any_req   = 1'b1;
            grant_idx = GW'(idx);
         end
      end
   end

   // Address decode of the candidate; the subtraction wraps below ADDR_LO so one compare covers both bounds.
   always_comb begin
      sel_addr   = M_ARADDR[grant_idx*AXI_AWIDTH +: AXI_AWIDTH];
      sel_prot   = M_ARPROT[grant_idx*3 +: 3];
      sel_offset = sel_addr - ADDR_LO;
      in_range   = (sel_offset <= SPAN);
   end

   // FSM state register.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Grant/request bookkeeping registers; last_grant resets so master 0 wins first.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         last_grant_q <= GW'(NUM_M - 1);
         gnt_q        <= '0;
         addr_q       <= '0;
         prot_q       <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         gnt_q        <= gnt_d;
         addr_q       <= addr_d;
         prot_q       <= prot_d;
      end
   end

   // Next-state logic: latch the request on grant, advance on slave/master handshakes.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt_d        = gnt_q;
      addr_d       = addr_q;
      prot_d       = prot_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               gnt_d   = grant_idx;
               addr_d  = sel_addr;
               prot_d  = sel_prot;
               state_d = in_range ? ST_ADDR : ST_ERR;
            end
         end
         ST_ADDR: begin
            if (S_ARREADY) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (S_RVALID && M_RREADY[gnt_q]) begin
               last_grant_d = gnt_q;
               state_d      = ST_IDLE;
            end
         end
         ST_ERR: begin
            if (M_RREADY[gnt_q]) begin
               last_grant_d = gnt_q;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output steering; everything is held low while ARESETN is asserted, even in IDLE.
   always_comb begin
      M_ARREADY = '0;
      M_RDATA   = '0;
      M_RRESP   = '0;
      M_RVALID  = '0;
      S_ARADDR  = '0;
      S_ARPROT  = '0;
      S_ARVALID = 1'b0;
      S_RREADY  = 1'b0;
      if (ARESETN) begin
         case (state_q)
            ST_IDLE: begin
               if (any_req) begin
                  M_ARREADY[grant_idx] = 1'b1;
               end
            end
            ST_ADDR: begin
               S_ARVALID = 1'b1;
               S_ARADDR  = addr_q;
               S_ARPROT  = prot_q;
            end
            ST_DATA: begin
               M_RVALID[gnt_q]                       = S_RVALID;
               M_RDATA[gnt_q*AXI_DWIDTH +: AXI_DWIDTH] = S_RDATA;
               M_RRESP[gnt_q*2 +: 2]                 = S_RRESP;
               S_RREADY                              = M_RREADY[gnt_q];
            end
            ST_ERR: begin
               M_RVALID[gnt_q]       = 1'b1;
               M_RRESP[gnt_q*2 +: 2] = 2'b11;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Self-checking bench for axil_rd_arbiter with three masters (non power-of-two grant space).
// Directed scenarios followed by randomized reads checked against a transaction-level model.
// Inputs change on the falling edge, outputs are sampled 1 ns later.
module tb_axil_rd_arbiter;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;

   logic              ACLK = 1'b0;
   logic              ARESETN;
   logic [N*AW-1:0]   M_ARADDR;
   logic [N*3-1:0]    M_ARPROT;
   logic [N-1:0]      M_ARVALID;
   logic [N-1:0]      M_ARREADY;
   logic [N*DW-1:0]   M_RDATA;
   logic [N*2-1:0]    M_RRESP;
   logic [N-1:0]      M_RVALID;
   logic [N-1:0]      M_RREADY;
   logic [AW-1:0]     S_ARADDR;
   logic [2:0]        S_ARPROT;
   logic              S_ARVALID;
   logic              S_ARREADY;
   logic [DW-1:0]     S_RDATA;
   logic [1:0]        S_RRESP;
   logic              S_RVALID;
   logic              S_RREADY;

   axil_rd_arbiter #(
      .NUM_M      (N),
      .AXI_AWIDTH (AW),
      .AXI_DWIDTH (DW),
      .ADDR_LO    (32'h00000000),
      .ADDR_HI    (32'h3FFFFFFF)
   ) dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .M_ARADDR  (M_ARADDR),
      .M_ARPROT  (M_ARPROT),
      .M_ARVALID (M_ARVALID),
      .M_ARREADY (M_ARREADY),
      .M_RDATA   (M_RDATA),
      .M_RRESP   (M_RRESP),
      .M_RVALID  (M_RVALID),
      .M_RREADY  (M_RREADY),
      .S_ARADDR  (S_ARADDR),
      .S_ARPROT  (S_ARPROT),
      .S_ARVALID (S_ARVALID),
      .S_ARREADY (S_ARREADY),
      .S_RDATA   (S_RDATA),
      .S_RRESP   (S_RRESP),
      .S_RVALID  (S_RVALID),
      .S_RREADY  (S_RREADY)
   );

   always #5 ACLK = ~ACLK;

   int n_chk  = 0;
   int n_pass = 0;

   // Transaction-level model state: per-master request and the last master served.
   logic [AW-1:0] maddr [N];
   logic [2:0]    mprot [N];
   int            lg;
   int            order_log [$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Round-robin rule: first requester after the last served master, wrapping over N.
   function automatic int pick(input logic [N-1:0] v);
      for (int k = 1; k <= N; k++) begin
         if (v[(lg + k) % N]) return (lg + k) % N;
      end
      return -1;
   endfunction

   function automatic logic in_window(input logic [AW-1:0] a);
      return (a <= 32'h3FFFFFFF);
   endfunction

   task automatic drive_masters();
      for (int i = 0; i < N; i++) begin
         M_ARADDR[i*AW +: AW] = maddr[i];
         M_ARPROT[i*3 +: 3]   = mprot[i];
      end
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_arready"}, M_ARREADY, 0);
      chk({tag, "_rvalid"},  M_RVALID,  0);
      chk({tag, "_s_arvalid"}, S_ARVALID, 0);
      chk({tag, "_s_rready"},  S_RREADY,  0);
      chk({tag, "_s_araddr"},  S_ARADDR,  0);
      chk({tag, "_rdata"},     M_RDATA,   0);
   endtask

   task automatic do_reset();
      @(negedge ACLK);
      ARESETN = 1'b0;
      M_ARVALID = '0; M_RREADY = '0; S_ARREADY = 1'b0; S_RVALID = 1'b0;
      #1 check_quiet("rst");
      @(negedge ACLK);
      ARESETN = 1'b1;
      lg = N - 1;
   endtask

   // One complete read, starting with the grant cycle and ending with the R handshake cycle.
   task automatic run_txn(input logic [N-1:0] vmask, input int ar_wait, input int r_wait,
                          input int rr_wait, input logic [DW-1:0] rdata, input logic [1:0] rresp);
      int            g;
      logic          inr;
      logic [N*DW-1:0] ev_data;
      logic [N*2-1:0]  ev_resp;
      g   = pick(vmask);
      inr = in_window(maddr[g]);
      order_log.push_back(g);

      @(negedge ACLK);
      drive_masters();
      M_ARVALID = vmask;
      S_ARREADY = 1'b0;
      S_RVALID  = 1'b0;
      M_RREADY  = N'($urandom) & ~(N'(1) << g);
      #1;
      chk("grant_arready", M_ARREADY, N'(1) << g);
      chk("grant_rvalid",  M_RVALID, 0);
      chk("grant_s_arvalid", S_ARVALID, 0);

      @(negedge ACLK);
      M_ARVALID = vmask & ~(N'(1) << g);
      if (inr) begin
         for (int i = 0; i <= ar_wait; i++) begin
            if (i > 0) @(negedge ACLK);
            S_ARREADY = (i == ar_wait);
            #1;
            chk("addr_s_arvalid", S_ARVALID, 1);
            chk("addr_s_araddr",  S_ARADDR, maddr[g]);
            chk("addr_s_arprot",  S_ARPROT, mprot[g]);
            chk("addr_holdoff",   M_ARREADY, 0);
            chk("addr_rvalid",    M_RVALID, 0);
            chk("addr_s_rready",  S_RREADY, 0);
         end
         for (int i = 0; i < r_wait; i++) begin
            @(negedge ACLK);
            S_ARREADY   = 1'b0;
            M_RREADY[g] = 1'($urandom);
            #1;
            chk("wait_s_arvalid", S_ARVALID, 0);
            chk("wait_s_araddr",  S_ARADDR, 0);
            chk("wait_rvalid",    M_RVALID, 0);
            chk("wait_s_rready",  S_RREADY, M_RREADY[g]);
         end
         ev_data = '0; ev_data[g*DW +: DW] = rdata;
         ev_resp = '0; ev_resp[g*2 +: 2]   = rresp;
         for (int i = 0; i <= rr_wait; i++) begin
            @(negedge ACLK);
            S_ARREADY   = 1'b0;
            S_RVALID    = 1'b1;
            S_RDATA     = rdata;
            S_RRESP     = rresp;
            M_RREADY[g] = (i == rr_wait);
            #1;
            chk("data_rvalid",   M_RVALID, N'(1) << g);
            chk("data_rdata",    M_RDATA, ev_data);
            chk("data_rresp",    M_RRESP, ev_resp);
            chk("data_s_rready", S_RREADY, (i == rr_wait));
            chk("data_holdoff",  M_ARREADY, 0);
         end
      end else begin
         ev_resp = '0; ev_resp[g*2 +: 2] = 2'b11;
         for (int i = 0; i <= rr_wait; i++) begin
            if (i > 0) @(negedge ACLK);
            M_RREADY[g] = (i == rr_wait);
            #1;
            chk("err_rvalid",    M_RVALID, N'(1) << g);
            chk("err_rresp",     M_RRESP, ev_resp);
            chk("err_rdata",     M_RDATA, 0);
            chk("err_s_arvalid", S_ARVALID, 0);
            chk("err_s_rready",  S_RREADY, 0);
            chk("err_holdoff",   M_ARREADY, 0);
         end
      end
      lg = g;
   endtask

   initial begin
      logic [N-1:0] vm;
      int           exp_order [4];
      ARESETN = 1'b0;
      M_ARADDR = '0; M_ARPROT = '0; M_ARVALID = '0; M_RREADY = '0;
      S_ARREADY = 1'b0; S_RDATA = '0; S_RRESP = '0; S_RVALID = 1'b0;
      for (int i = 0; i < N; i++) begin maddr[i] = '0; mprot[i] = '0; end
      lg = N - 1;

      // Reset with all masters requesting: nothing may be granted or driven.
      M_ARVALID = '1;
      for (int c = 0; c < 2; c++) begin
         @(negedge ACLK);
         #1 check_quiet("in_reset");
      end
      @(negedge ACLK);
      ARESETN = 1'b1;
      M_ARVALID = '0;

      // Single read from M0, data three cycles after the address handshake.
      maddr[0] = 32'h100; mprot[0] = 3'b010;
      run_txn(3'b001, 0, 2, 0, 32'hDEADBEEF, 2'b00);
      @(negedge ACLK);
      M_ARVALID = '0; S_RVALID = 1'b0; M_RREADY = '0;
      #1 check_quiet("after_single");

      // M0 and M1 contend for four reads after reset.
      do_reset();
      order_log.delete();
      maddr[0] = 32'h1000; maddr[1] = 32'h2000; mprot[1] = 3'b101;
      for (int i = 0; i < 4; i++) begin
         run_txn(3'b011, 0, 0, 0, 32'hA000_0000 + 32'(i), 2'b00);
      end
      exp_order = '{0, 1, 0, 1};
      for (int i = 0; i < 4; i++) chk("rr_order", order_log[i], exp_order[i]);

      // Out-of-range read from M1 returns DECERR without touching the slave.
      maddr[1] = 32'h40000000;
      run_txn(3'b010, 0, 0, 2, 32'h0, 2'b00);

      // Slave address stall then master read stall.
      maddr[0] = 32'h300; mprot[0] = 3'b001;
      run_txn(3'b001, 5, 1, 3, 32'h1234_5678, 2'b00);

      // SLVERR forwarded to M2 at the top edge of the window; lowest address to M0.
      maddr[2] = 32'h3FFFFFFF; mprot[2] = 3'b111;
      run_txn(3'b100, 1, 0, 0, 32'hCAFE_F00D, 2'b10);
      maddr[0] = 32'h0;
      run_txn(3'b001, 0, 1, 1, 32'h0BAD_0001, 2'b01);

      // Randomized contention, addresses and handshake timing.
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < N; i++) begin
            maddr[i] = ($urandom_range(0, 3) == 0) ? (32'h40000000 | 32'($urandom)) : (32'($urandom) & 32'h3FFFFFFF);
            mprot[i] = 3'($urandom);
         end
         vm = N'($urandom_range(1, 7));
         run_txn(vm, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 32'($urandom), 2'($urandom));
      end

      // Make M0 the last served, then abandon an M1 read in DATA with reset.
      maddr[0] = 32'h500; maddr[1] = 32'h600;
      run_txn(3'b001, 0, 0, 0, 32'h55, 2'b00);
      @(negedge ACLK);
      M_ARVALID = 3'b010; S_RVALID = 1'b0; M_RREADY = '0; S_ARREADY = 1'b0;
      drive_masters();
      #1 chk("mid_grant", M_ARREADY, 3'b010);
      @(negedge ACLK);
      M_ARVALID = '0; S_ARREADY = 1'b1;
      #1 chk("mid_addr", S_ARADDR, 32'h600);
      @(negedge ACLK);
      S_ARREADY = 1'b0; S_RVALID = 1'b1; S_RDATA = 32'h77;
      #1 chk("mid_data_rvalid", M_RVALID, 3'b010);
      @(negedge ACLK);
      ARESETN = 1'b0;
      #1 check_quiet("mid_reset");
      @(negedge ACLK);
      ARESETN = 1'b1; S_RVALID = 1'b0;
      lg = N - 1;
      #1 check_quiet("post_reset");
      run_txn(3'b011, 0, 0, 0, 32'h99, 2'b00);
      chk("post_reset_grant", order_log[order_log.size()-1], 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/axil_rd_arbiter.md
AXIL_RD_ARBITER -- requirements
Module: axil_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_M, default 2, number of AXI4-Lite read masters (2..8).
REQ-002 SHALL have parameter AXI_AWIDTH, default 32, address width.
REQ-003 SHALL have parameter AXI_DWIDTH, default 32, data width.
REQ-004 SHALL have parameter ADDR_LO, default 32'h00000000, lowest address forwarded to the slave.
REQ-005 SHALL have parameter ADDR_HI, default 32'h3FFFFFFF, highest address forwarded to the slave.
REQ-006 SHALL have port ACLK  input  1  clock, all logic on rising edge.
REQ-007 SHALL have port ARESETN  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port M_ARADDR  input  NUM_M*AXI_AWIDTH  master read addresses, master i at slice i.
REQ-009 SHALL have port M_ARPROT  input  NUM_M*3  master protection bits.
REQ-010 SHALL have port M_ARVALID  input  NUM_M  master address valid.
REQ-011 SHALL have port M_ARREADY  output  NUM_M  master address ready.
REQ-012 SHALL have port M_RDATA  output  NUM_M*AXI_DWIDTH  master read data.
REQ-013 SHALL have port M_RRESP  output  NUM_M*2  master read response.
REQ-014 SHALL have port M_RVALID  output  NUM_M  master read valid.
REQ-015 SHALL have port M_RREADY  input  NUM_M  master read ready.
REQ-016 SHALL have ports S_ARADDR/S_ARPROT/S_ARVALID (outputs, AXI_AWIDTH/3/1) and S_ARREADY (input, 1), slave address channel.
REQ-017 SHALL have ports S_RDATA/S_RRESP/S_RVALID (inputs, AXI_DWIDTH/2/1) and S_RREADY (output, 1), slave data channel.

Function
REQ-018 SHALL implement FSM states IDLE, ADDR, DATA, ERR; at most one transaction in flight.
REQ-019 IDLE: if any M_ARVALID is set, SHALL grant g = first set index scanning upward from last_grant+1 (mod NUM_M), i.e. round-robin.
REQ-020 SHALL assert M_ARREADY[g] combinationally for exactly the grant cycle in IDLE, and SHALL latch the address, prot, and g.
REQ-021 On grant, ADDR_LO <= address <= ADDR_HI SHALL go to ADDR; any other address SHALL go to ERR.
REQ-022 ADDR: S_ARVALID=1, with S_ARADDR/S_ARPROT taken from the latched registers and held stable; S_ARREADY=1 SHALL move to DATA.
REQ-023 DATA: SHALL drive M_RVALID[g]=S_RVALID, M_RDATA[g]=S_RDATA, M_RRESP[g]=S_RRESP, S_RREADY=M_RREADY[g]; the S_RVALID&S_RREADY handshake SHALL update last_grant=g and go to IDLE.
REQ-024 ERR: SHALL drive M_RVALID[g]=1, M_RRESP[g]=2'b11 (DECERR), M_RDATA[g]=0 without touching the slave; M_RREADY[g] SHALL update last_grant=g and go to IDLE.
REQ-025 Non-granted masters SHALL see ARREADY=0, RVALID=0, RDATA=0, RRESP=0 at all times.
REQ-026 Outside ADDR, S_ARVALID=0 and S_ARADDR=0; outside DATA, S_RREADY=0.
REQ-027 Minimum latency: grant at cycle T, S_ARVALID at T+1, first possible M_RVALID at T+2; back-to-back grant earliest the cycle after an R handshake.
REQ-028 M_ARVALID rising while not in IDLE SHALL be held off (ARREADY=0) until the next IDLE.
REQ-029 Unused grant encodings (NUM_M not a power of two) SHALL never be produced.

Reset
REQ-030 ARESETN=0 at a rising ACLK edge SHALL force IDLE, last_grant=NUM_M-1 (master 0 first priority), latched address/prot/g=0.
REQ-031 During and after reset, all M_ARREADY, M_RVALID, S_ARVALID, S_RREADY SHALL be 0; reset mid-transaction SHALL abandon it with no response.

Verification
REQ-032 Single read, M0 addr 0x100, slave returns 0xDEADBEEF/OKAY after 3 cycles -> M_RDATA[0]=0xDEADBEEF, M_RRESP[0]=0, one RVALID pulse.
REQ-033 M0 and M1 ARVALID held simultaneously for 4 reads after reset -> grant order 0,1,0,1.
REQ-034 M1 reads 0x40000000 (out of range) -> slave untouched, M_RRESP[1]=2'b11, M_RDATA[1]=0.
REQ-035 Slave holds S_ARREADY=0 for 5 cycles, then M_RREADY[0]=0 for 3 cycles -> S_ARVALID/address stable throughout, S_RREADY mirrors M_RREADY[0], data delivered intact.
REQ-036 ARESETN dropped in DATA state -> next cycle IDLE, all valids/readies 0, next grant goes to M0.
REQ-037 Slave returns SLVERR 2'b10 -> forwarded unchanged to the granted master.
